output_mem: RTL
===============

Name: output_mem

Overview:
- Output-side pixel buffer for the rotate engine; sits directly downstream of the input buffer's pixel read ports (B/G/R byte stream).
- Accepts one rotated BGR pixel per cycle and packs the 3-byte pixels into little-endian 32-bit words.
- Queues the packed words in a first-word-fall-through FIFO, which the AHB master drains for destination writes.
- A frame-end marker flushes any partial word, zero-padded.

Parameters:
DEPTH, 16, FIFO depth in 32-bit words (power of 2)
AW, 4, log2(DEPTH)

Ports:
I_OMEM_HCLK  input  1  clock
I_OMEM_HRESET_N  input  1  reset; synchronous, active-low
I_OMEM_PIXEL_B  input  8  blue byte of incoming pixel
I_OMEM_PIXEL_G  input  8  green byte
I_OMEM_PIXEL_R  input  8  red byte
I_OMEM_VALID  input  1  pixel valid
I_OMEM_LAST  input  1  qualifies the last pixel of the frame (sampled with VALID&&READY)
O_OMEM_READY  output  1  pixel accept
O_OMEM_WDATA  output  32  FIFO head word to the AHB master
O_OMEM_WVALID  output  1  FIFO non-empty
I_OMEM_WREADY  input  1  master pops the head word
O_OMEM_COUNT  output  AW+1  words held in FIFO (0..DEPTH)
O_OMEM_DONE  output  1  one-cycle pulse: last word of frame enqueued
I_OMEM_CLEAR  input  1  synchronous soft clear (abort frame)

Behaviour:
- Clock and reset: one clock, I_OMEM_HCLK. Reset I_OMEM_HRESET_N is synchronous, active-low.
- Priority: reset > CLEAR > normal operation.
- Reset and CLEAR behaviour:
  - Both zero the FIFO pointers, COUNT, accumulator, byte count nb and DONE, and set state RUN.
  - FIFO storage is not reset.
- Output values during/after reset:
  - While reset is low: READY=0, WVALID=0, WDATA=0, COUNT=0, DONE=0.
  - WDATA reads 0 whenever the FIFO is empty.
- States:
  - RUN: READY = (COUNT < DEPTH).
  - FLUSH: READY = 0.
- Pixel accept = VALID && READY. Accumulator acc holds 0..3 residual bytes; nb is its byte count. On accept, byte order within a pixel is B, G, R (increasing byte address):
  - nb=0: no push; acc={R,G,B}; nb=3.
  - nb=1: push {R,G,B,acc[7:0]}; nb=0.
  - nb=2: push {G,B,acc[15:0]}; acc=R; nb=1.
  - nb=3: push {B,acc[23:0]}; acc={R,G}; nb=2.
  - 4 pixels produce exactly 3 words; at most one push per accepted pixel.
- LAST accepted:
  - Resulting nb=0: DONE pulses the next cycle; stay RUN.
  - Resulting nb>0: go to FLUSH.
- FLUSH:
  - When COUNT < DEPTH (registered), push acc zero-extended to 32 bits (unused upper bytes = 0x00).
  - In the same cycle: nb=0, DONE pulses the next cycle, return to RUN.
  - If the FIFO is full, wait in FLUSH.
- FIFO:
  - First-word fall-through: a word pushed at edge N appears on WDATA/WVALID from edge N onward.
  - Pop = WVALID && WREADY.
  - Simultaneous push and pop: COUNT unchanged.
  - Pop when empty: ignored.
  - Push when full: cannot occur (READY low; FLUSH waits).
  - Pointers wrap modulo DEPTH.
- COUNT is registered. READY depends only on registered state, never on WREADY (no combinational path from WREADY to READY).
- Reset or CLEAR mid-FLUSH: residual bytes are discarded, no DONE pulse.

Optional Feature:
OMEM_PIXCNT_EN:
- Defined:
  - Adds output O_OMEM_PIXCNT [15:0], counting accepted pixels in the current frame, saturating at 0xFFFF.
  - Reset/CLEAR to 0.
  - Holds its final value through the DONE pulse; clears on the first accept of the next frame.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Packing:
  - Stimulus: 4 pixels (B,G,R) = (01,02,03), (04,05,06), (07,08,09), (0A,0B,0C), LAST on the 4th, WREADY=1.
  - Response: words 0x04030201, 0x08070605, 0x0C0B0A09 in order; DONE pulses 1 cycle after the 4th accept; no FLUSH entered.
- Flush:
  - Stimulus: single pixel (AA,BB,CC) with LAST.
  - Response: READY=0 for exactly one cycle (FLUSH); word 0x00CCBBAA enqueued; DONE pulses once.
- Full:
  - Stimulus: WREADY=0; stream pixels continuously.
  - Response: after 22 accepts COUNT=16 and READY=0. Then raise WREADY for one cycle: COUNT=15 and READY=1 next cycle.
- Push/pop collision:
  - Stimulus: COUNT=5 with nb=1; accept a pixel and pop in the same cycle.
  - Response: COUNT stays 5; head advances.
- CLEAR:
  - Stimulus: assert CLEAR with nb=2, COUNT=3.
  - Response: COUNT=0, WVALID=0, WDATA=0 next cycle. Next pixel (11,22,33), then (44,55,66) gives word 0x44332211 (no stale bytes).
- Reset mid-FLUSH:
  - Stimulus: COUNT=16, LAST leaves nb=2, assert reset for 1 cycle.
  - Response: FLUSH abandoned, no DONE; COUNT=0; READY=1 after reset releases.

Source files
------------

// File: rtl/output_mem_if.sv
// Output-buffer bus bundle: pixel in, packed words out, status.
// Ports: slave = buffer side, master = pixel source / AHB master side.
// The pixel counter port exists only when OMEM_PIXCNT_EN is defined.
interface output_mem_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
);
    logic [7:0]  I_OMEM_PIXEL_B;
    logic [7:0]  I_OMEM_PIXEL_G;
    logic [7:0]  I_OMEM_PIXEL_R;
    logic        I_OMEM_VALID;
    logic        I_OMEM_LAST;
    logic        O_OMEM_READY;
    logic [31:0] O_OMEM_WDATA;
    logic        O_OMEM_WVALID;
    logic        I_OMEM_WREADY;
    logic [AW:0] O_OMEM_COUNT;
    logic        O_OMEM_DONE;
    logic        I_OMEM_CLEAR;
`ifdef OMEM_PIXCNT_EN
    logic [15:0] O_OMEM_PIXCNT;

    modport slave (
        input  I_OMEM_PIXEL_B, I_OMEM_PIXEL_G, I_OMEM_PIXEL_R,
        input  I_OMEM_VALID, I_OMEM_LAST, I_OMEM_WREADY,
        input  I_OMEM_CLEAR,
        output O_OMEM_READY, O_OMEM_WDATA, O_OMEM_WVALID,
        output O_OMEM_COUNT, O_OMEM_DONE, O_OMEM_PIXCNT
    );
    modport master (
        output I_OMEM_PIXEL_B, I_OMEM_PIXEL_G, I_OMEM_PIXEL_R,
        output I_OMEM_VALID, I_OMEM_LAST, I_OMEM_WREADY,
        output I_OMEM_CLEAR,
        input  O_OMEM_READY, O_OMEM_WDATA, O_OMEM_WVALID,
        input  O_OMEM_COUNT, O_OMEM_DONE, O_OMEM_PIXCNT
    );
`else
    modport slave (
        input  I_OMEM_PIXEL_B, I_OMEM_PIXEL_G, I_OMEM_PIXEL_R,
        input  I_OMEM_VALID, I_OMEM_LAST, I_OMEM_WREADY,
        input  I_OMEM_CLEAR,
        output O_OMEM_READY, O_OMEM_WDATA, O_OMEM_WVALID,
        output O_OMEM_COUNT, O_OMEM_DONE
    );
    modport master (
        output I_OMEM_PIXEL_B, I_OMEM_PIXEL_G, I_OMEM_PIXEL_R,
        output I_OMEM_VALID, I_OMEM_LAST, I_OMEM_WREADY,
        output I_OMEM_CLEAR,
        input  O_OMEM_READY, O_OMEM_WDATA, O_OMEM_WVALID,
        input  O_OMEM_COUNT, O_OMEM_DONE
    );
`endif
endinterface

// File: rtl/output_mem.sv
// Output pixel buffer: packs BGR pixels into LE 32-bit words, FWFT FIFO.
// Ports: I_OMEM_HCLK, I_OMEM_HRESET_N (sync, active-low), bus (slave).
// Optional OMEM_PIXCNT_EN adds a saturating per-frame pixel counter.
module output_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         I_OMEM_HCLK,
    input  logic         I_OMEM_HRESET_N,
    output_mem_if.slave  bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [23:0]   r_acc;
    logic [1:0]    r_nb;
    logic          r_done;
    state_t        r_state;

    logic          w_clr;
    logic          w_notfull;
    logic          w_ready;
    logic          w_accept;
    logic          w_wvalid;
    logic          w_pop;
    logic          w_flush_go;
    logic          w_push;
    logic [31:0]   w_pdata;
    logic [23:0]   w_acc_n;
    logic [1:0]    w_nb_n;

    assign w_clr      = !I_OMEM_HRESET_N || bus.I_OMEM_CLEAR;
    assign w_notfull  = (r_count != LP_FULL);
    // Built from registered state only: no WREADY-to-READY path.
    assign w_ready    = I_OMEM_HRESET_N && (r_state == RUN)
                        && w_notfull;
    assign w_accept   = bus.I_OMEM_VALID && w_ready;
    assign w_wvalid   = I_OMEM_HRESET_N && (r_count != '0);
    assign w_pop      = w_wvalid && bus.I_OMEM_WREADY;
    assign w_flush_go = (r_state == FLUSH) && w_notfull;

    // Packer: residual bytes sit in the low end of acc, upper bytes zero,
    // so a flush is simply acc zero-extended.
    always_comb begin
        w_push  = 1'b0;
        w_pdata = 32'h0;
        w_acc_n = r_acc;
        w_nb_n  = r_nb;
        if (w_flush_go) begin
            w_push  = 1'b1;
            w_pdata = {8'h00, r_acc};
            w_acc_n = 24'h0;
            w_nb_n  = 2'd0;
        end else if (w_accept) begin
            w_nb_n = r_nb - 2'd1;
            unique case (r_nb)
                2'd0: begin
                    w_acc_n = {bus.I_OMEM_PIXEL_R,
                               bus.I_OMEM_PIXEL_G,
                               bus.I_OMEM_PIXEL_B};
                end
                2'd1: begin
                    w_push  = 1'b1;
                    w_pdata = {bus.I_OMEM_PIXEL_R,
                               bus.I_OMEM_PIXEL_G,
                               bus.I_OMEM_PIXEL_B,
                               r_acc[7:0]};
                    w_acc_n = 24'h0;
                end
                2'd2: begin
                    w_push  = 1'b1;
                    w_pdata = {bus.I_OMEM_PIXEL_G,
                               bus.I_OMEM_PIXEL_B,
                               r_acc[15:0]};
                    w_acc_n = {16'h0, bus.I_OMEM_PIXEL_R};
                end
                2'd3: begin
                    w_push  = 1'b1;
                    w_pdata = {bus.I_OMEM_PIXEL_B, r_acc};
                    w_acc_n = {8'h0,
                               bus.I_OMEM_PIXEL_R,
                               bus.I_OMEM_PIXEL_G};
                end
            endcase
        end
    end

    // Storage carries no reset; only pointers/count are cleared.
    always_ff @(posedge I_OMEM_HCLK) begin
        if (w_push && !w_clr) begin
            r_mem[r_wptr] <= w_pdata;
        end
    end

    always_ff @(posedge I_OMEM_HCLK) begin
        if (w_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_acc   <= 24'h0;
            r_nb    <= 2'd0;
            r_done  <= 1'b0;
            r_state <= RUN;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            r_acc  <= w_acc_n;
            r_nb   <= w_nb_n;
            r_done <= 1'b0;
            if (w_flush_go) begin
                r_state <= RUN;
                r_done  <= 1'b1;
            end else if (w_accept && bus.I_OMEM_LAST) begin
                if (w_nb_n == 2'd0) begin
                    r_done <= 1'b1;
                end else begin
                    r_state <= FLUSH;
                end
            end
        end
    end

    assign bus.O_OMEM_READY  = w_ready;
    assign bus.O_OMEM_WVALID = w_wvalid;
    assign bus.O_OMEM_WDATA  = w_wvalid ? r_mem[r_rptr] : 32'h0;
    assign bus.O_OMEM_COUNT  = r_count;
    assign bus.O_OMEM_DONE   = r_done;

`ifdef OMEM_PIXCNT_EN
    logic [15:0] r_pixcnt;
    logic        r_first;

    // r_first marks "next accept starts a new frame", so the count
    // survives the DONE pulse and restarts lazily.
    always_ff @(posedge I_OMEM_HCLK) begin
        if (w_clr) begin
            r_pixcnt <= 16'h0;
            r_first  <= 1'b1;
        end else if (w_accept) begin
            r_first <= bus.I_OMEM_LAST;
            if (r_first) begin
                r_pixcnt <= 16'h1;
            end else if (r_pixcnt != 16'hFFFF) begin
                r_pixcnt <= r_pixcnt + 16'h1;
            end
        end
    end

    assign bus.O_OMEM_PIXCNT = r_pixcnt;
`endif
endmodule
